// File: rtl/latency_credit_fifo_pkg.sv
// Shared types and constants for the latency-credit FIFO: state encoding,
// the pipe latency cap and the width of the credit/occupancy counters.
package latency_credit_fifo_pkg;

  localparam int MAX_PIPE_LATENCY = 100;

  typedef enum logic {
    ST_DRAIN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/latency_credit_fifo_fwft_ram_fifo.sv
// First-word-fall-through FIFO: DEPTH-1 entry memory plus one output register.
// An empty FIFO bypasses a push straight into the output register.
module fwft_ram_fifo
  import latency_credit_fifo_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int MEM_DEPTH = DEPTH - 1;
  localparam int PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_DEPTH - 1);

  logic [WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             pop_fire, push_ok, out_free, mem_wr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = !out_valid_q;
  assign dout_o       = out_data_q;
  assign dout_valid_o = out_valid_q;

  always_comb begin
    pop_fire    = pop_i && out_valid_q;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    push_ok     = push_i && (!full_o || pop_fire);
    out_free    = !out_valid_q || pop_fire;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    mem_wr      = 1'b0;
    if (out_free) begin
      if (mem_cnt_q != '0) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d    = next_ptr(rd_ptr_q);
        mem_cnt_d   = mem_cnt_d - CW'(1);
      end else if (push_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = push_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (push_ok && !(out_free && (mem_cnt_q == '0))) begin
      mem_wr    = 1'b1;
      wr_ptr_d  = next_ptr(wr_ptr_q);
      mem_cnt_d = mem_cnt_d + CW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_fire);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: rtl/latency_credit_fifo.sv
// Credit-issuing consumer behind a non-stallable fixed-latency pipe: grants one
// credit per free slot, drains stale pipe contents after reset, buffers in a FWFT FIFO.
module latency_credit_fifo
  import latency_credit_fifo_pkg::*;
#(
  parameter int  WIDTH        = 32,
  parameter int  PIPE_LATENCY = 8,
  parameter int  DEPTH        = 16,
  localparam int CW           = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issueValid,
  output logic             issueReady,
  input  logic             pipeValid,
  input  logic [WIDTH-1:0] pipeData,
  output logic [WIDTH-1:0] dout,
  output logic             doutValid,
  input  logic             doutReady,
  output logic             overflowErr,
  output logic [CW-1:0]    creditCount
);

  localparam int LAT_W = $clog2(MAX_PIPE_LATENCY + 1);

  // Handshakes: issue fires on issueValid&&issueReady, pop on doutValid&&doutReady;
  // pipeValid cannot be stalled, so it is taken (or dropped) on every edge in RUN.
  state_e          state_q;
  logic [LAT_W-1:0] drain_q;
  logic [CW-1:0]    credits_q;
  logic             overflow_q;
  logic             issue_fire, pop_fire, push, fifo_full, fifo_empty;

  assign issueReady  = (state_q == ST_RUN) && (credits_q != '0);
  assign creditCount = credits_q;
  assign overflowErr = overflow_q;
  assign issue_fire  = issueValid && issueReady;
  assign pop_fire    = doutReady && !fifo_empty;
  assign push        = pipeValid && (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_DRAIN;
      drain_q    <= LAT_W'(PIPE_LATENCY);
      credits_q  <= CW'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        // The external pipe is not reset; wait out anything still inside it.
        ST_DRAIN: begin
          if (drain_q <= LAT_W'(1)) begin
            state_q <= ST_RUN;
          end else begin
            drain_q <= drain_q - LAT_W'(1);
          end
        end
        ST_RUN: begin
          credits_q <= credits_q - CW'(issue_fire) + CW'(pop_fire);
          if (push && fifo_full && !pop_fire) begin
            overflow_q <= 1'b1;
          end
        end
        default: state_q <= ST_DRAIN;
      endcase
    end
  end

  fwft_ram_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_data_i  (pipeData),
    .pop_i        (doutReady),
    .dout_o       (dout),
    .dout_valid_o (doutValid),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

endmodule

// File: tb/tb_latency_credit_fifo.sv
// Bench for latency_credit_fifo: models the external fixed-latency pipe and the
// expected credit/queue behaviour at transaction level.
module tb_latency_credit_fifo;

  localparam int W  = 32;
  localparam int L  = 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic          clk;
  logic          rst_n;
  logic          issueValid;
  logic          issueReady;
  logic          pipeValid;
  logic [W-1:0]  pipeData;
  logic [W-1:0]  dout;
  logic          doutValid;
  logic          doutReady;
  logic          overflowErr;
  logic [CW-1:0] creditCount;

  int checks   = 0;
  int failures = 0;

  // External pipe model and reference state
  logic          pv [L];
  logic [W-1:0]  pd [L];
  logic [W-1:0]  exp_q[$];
  logic          m_running;
  int            m_drain;
  int            m_credits;
  logic          m_overflow;
  int            n_issued;

  latency_credit_fifo #(
    .WIDTH        (W),
    .PIPE_LATENCY (L),
    .DEPTH        (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issueValid  (issueValid),
    .issueReady  (issueReady),
    .pipeValid   (pipeValid),
    .pipeData    (pipeData),
    .dout        (dout),
    .doutValid   (doutValid),
    .doutReady   (doutReady),
    .overflowErr (overflowErr),
    .creditCount (creditCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic model_ready();
    return m_running && (m_credits > 0);
  endfunction

  // Called at a negedge: drive one cycle of inputs, advance the reference
  // model across the coming posedge, and return at the following negedge.
  task automatic step(input logic iv, input logic dr, input logic rst,
                      input logic inj, input logic [W-1:0] data);
    logic         issue, pop, arrive;
    logic [W-1:0] arr_data;
    int           occ;
    issueValid = iv;
    doutReady  = dr;
    rst_n      = !rst;
    arrive     = pv[L-1] | inj;
    arr_data   = inj ? data : pd[L-1];
    pipeValid  = arrive;
    pipeData   = arr_data;
    issue      = iv && model_ready();
    for (int i = L - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = issue;
    pd[0] = data;
    if (issue) n_issued++;
    if (rst) begin
      m_running  = 1'b0;
      m_drain    = L;
      m_credits  = D;
      m_overflow = 1'b0;
      exp_q.delete();
    end else if (!m_running) begin
      m_drain--;
      if (m_drain == 0) m_running = 1'b1;
    end else begin
      occ = exp_q.size();
      pop = dr && (occ > 0);
      if (pop) begin
        void'(exp_q.pop_front());
        m_credits++;
      end
      if (issue) m_credits--;
      if (arrive) begin
        if (occ == D && !pop) m_overflow = 1'b1;
        else exp_q.push_back(arr_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++; if (issueReady !== 1'b0) begin failures++; $display("FAIL rst_ready: got %0b want 0", issueReady); end
    checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", doutValid); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL rst_dout: got %h want 0", dout); end
    checks++; if (overflowErr !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %0b want 0", overflowErr); end
    checks++; if (creditCount !== CW'(D)) begin failures++; $display("FAIL rst_credits: got %0d want %0d", creditCount, D); end
    // Garbage from the unreset pipe must be ignored during drain
    for (int c = 0; c < L; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, W'($urandom));
      if (c < L - 1) begin
        checks++; if (issueReady !== 1'b0) begin failures++; $display("FAIL drain_ready c%0d: got %0b want 0", c, issueReady); end
      end
      checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL drain_valid c%0d: got %0b want 0", c, doutValid); end
    end
    checks++; if (issueReady !== 1'b1) begin failures++; $display("FAIL drain_end_ready: got %0b want 1", issueReady); end
    checks++; if (creditCount !== CW'(D)) begin failures++; $display("FAIL drain_end_credits: got %0d want %0d", creditCount, D); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL drain_nodata: got %0b want 0", doutValid); end
  endtask

  task automatic test_single();
    int lat;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5);
    lat = 1;
    while (doutValid !== 1'b1 && lat < 40) begin
      checks++; if (creditCount !== CW'(D - 1)) begin failures++; $display("FAIL single_credit_wait: got %0d want %0d", creditCount, D - 1); end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      lat++;
    end
    checks++; if (lat != L + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", lat, L + 1); end
    checks++; if (dout !== 32'hA5A5_A5A5) begin failures++; $display("FAIL single_data: got %h want a5a5a5a5", dout); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (doutValid !== 1'b1 || dout !== 32'hA5A5_A5A5) begin failures++; $display("FAIL single_hold: got %0b/%h want 1/a5a5a5a5", doutValid, dout); end
    checks++; if (creditCount !== CW'(D - 1)) begin failures++; $display("FAIL single_credit: got %0d want %0d", creditCount, D - 1); end
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL single_popped: got %0b want 0", doutValid); end
    checks++; if (creditCount !== CW'(D)) begin failures++; $display("FAIL single_credit_back: got %0d want %0d", creditCount, D); end
  endtask

  task automatic test_full_backpressure();
    int start, accepted;
    start    = n_issued;
    accepted = 0;
    for (int c = 0; c < D + L + 4; c++) begin
      checks++; if (issueReady !== model_ready()) begin failures++; $display("FAIL bp_ready c%0d: got %0b want %0b", c, issueReady, model_ready()); end
      if (issueReady === 1'b1) accepted++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0000 + W'(n_issued));
    end
    checks++; if (accepted != D) begin failures++; $display("FAIL bp_accepted: got %0d want %0d", accepted, D); end
    checks++; if (creditCount !== '0) begin failures++; $display("FAIL bp_credits: got %0d want 0", creditCount); end
    checks++; if (overflowErr !== 1'b0) begin failures++; $display("FAIL bp_ovf: got %0b want 0", overflowErr); end
    for (int k = 0; k < D; k++) begin
      checks++;
      if (doutValid !== 1'b1 || dout !== 32'h1000_0000 + W'(start + k)) begin
        failures++;
        $display("FAIL bp_order k%0d: got %0b/%h want 1/%h", k, doutValid, dout, 32'h1000_0000 + W'(start + k));
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    end
    checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL bp_empty: got %0b want 0", doutValid); end
    checks++; if (creditCount !== CW'(D)) begin failures++; $display("FAIL bp_credit_back: got %0d want %0d", creditCount, D); end
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 200; c++) begin
      checks++; if (issueReady !== model_ready()) begin failures++; $display("FAIL stream_ready c%0d: got %0b want %0b", c, issueReady, model_ready()); end
      step(1'b1, 1'b1, 1'b0, 1'b0, W'($urandom));
      checks++; if (doutValid !== (exp_q.size() > 0)) begin failures++; $display("FAIL stream_valid c%0d: got %0b want %0b", c, doutValid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        checks++; if (dout !== exp_q[0]) begin failures++; $display("FAIL stream_data c%0d: got %h want %h", c, dout, exp_q[0]); end
      end
      if (c >= L) begin
        checks++; if (creditCount !== CW'(D - L - 1)) begin failures++; $display("FAIL stream_credit c%0d: got %0d want %0d", c, creditCount, D - L - 1); end
      end
    end
    for (int c = 0; c < L + 4; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      if (exp_q.size() > 0) begin
        checks++; if (dout !== exp_q[0]) begin failures++; $display("FAIL stream_tail c%0d: got %h want %h", c, dout, exp_q[0]); end
      end
    end
    checks++; if (doutValid !== 1'b0 || creditCount !== CW'(D)) begin failures++; $display("FAIL stream_end: got %0b/%0d want 0/%0d", doutValid, creditCount, D); end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < D + L + 2; c++) step(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
    checks++; if (overflowErr !== 1'b0) begin failures++; $display("FAIL ovf_before: got %0b want 0", overflowErr); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (overflowErr !== 1'b1) begin failures++; $display("FAIL ovf_set: got %0b want 1", overflowErr); end
    for (int k = 0; k < D + 2; k++) begin
      if (exp_q.size() > 0) begin
        checks++; if (dout !== exp_q[0] || doutValid !== 1'b1) begin failures++; $display("FAIL ovf_drain k%0d: got %0b/%h want 1/%h", k, doutValid, dout, exp_q[0]); end
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      checks++; if (overflowErr !== 1'b1) begin failures++; $display("FAIL ovf_sticky k%0d: got %0b want 1", k, overflowErr); end
    end
    checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL ovf_dropped: got %0b want 0", doutValid); end
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++; if (overflowErr !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b want 0", overflowErr); end
    for (int c = 0; c < L; c++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
    for (int c = 0; c < L; c++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
    checks++; if (creditCount !== CW'(D - 9) || doutValid !== 1'b1) begin failures++; $display("FAIL mid_pre: got %0d/%0b want %0d/1", creditCount, doutValid, D - 9); end
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %0b want 0", doutValid); end
    checks++; if (issueReady !== 1'b0) begin failures++; $display("FAIL mid_ready: got %0b want 0", issueReady); end
    for (int c = 0; c < L; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++; if (doutValid !== 1'b0) begin failures++; $display("FAIL mid_stale c%0d: got %0b want 0", c, doutValid); end
    end
    checks++; if (issueReady !== 1'b1 || creditCount !== CW'(D)) begin failures++; $display("FAIL mid_after: got %0b/%0d want 1/%0d", issueReady, creditCount, D); end
  endtask

  task automatic test_random();
    logic iv, dr;
    for (int c = 0; c < 400; c++) begin
      iv = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 5);
      checks++; if (issueReady !== model_ready()) begin failures++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, issueReady, model_ready()); end
      step(iv, dr, 1'b0, 1'b0, W'($urandom));
      checks++; if (doutValid !== (exp_q.size() > 0)) begin failures++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, doutValid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        checks++; if (dout !== exp_q[0]) begin failures++; $display("FAIL rnd_data c%0d: got %h want %h", c, dout, exp_q[0]); end
      end
      checks++; if (creditCount !== CW'(m_credits)) begin failures++; $display("FAIL rnd_credit c%0d: got %0d want %0d", c, creditCount, m_credits); end
      checks++; if (overflowErr !== m_overflow) begin failures++; $display("FAIL rnd_ovf c%0d: got %0b want %0b", c, overflowErr, m_overflow); end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    issueValid = 1'b0;
    doutReady  = 1'b0;
    pipeValid  = 1'b0;
    pipeData   = '0;
    n_issued   = 0;
    m_running  = 1'b0;
    m_drain    = L;
    m_credits  = D;
    m_overflow = 1'b0;
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_full_backpressure();
    test_streaming();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
